// File: rtl/key_xor_stream.sv
// Key XOR stage: XORs accepted plaintext bytes with a 4-byte key indexed by the
// external key_counter. Optional CBC-like chaining via `define KEY_XOR_CHAIN_EN.
module key_xor_stream #(
  parameter int                    DATA_W  = 8,
  parameter logic [4*DATA_W-1:0]   KEY_RST = '0
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              key_wr_en,
  input  logic [1:0]        key_wr_idx,
  input  logic [DATA_W-1:0] key_wr_data,
  input  logic              start,
  input  logic              stop,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_in_valid,
  output logic              data_in_ready,
  input  logic [1:0]        key_count,
  input  logic              key_rollover,
  output logic              count_enable,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_valid,
  input  logic              data_out_ready,
  output logic              block_done,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  // Handshake: a byte transfers on a port in any cycle where valid and ready
  // are both high at the rising edge; valid never waits on ready.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic              stop_pend, stop_pend_nxt;
  logic              accept, pop;
  logic [DATA_W-1:0] key_q [4];
  logic [DATA_W-1:0] cipher;

  assign data_in_ready = (state == RUN) && (!data_out_valid || data_out_ready);
  assign accept        = data_in_valid && data_in_ready;
  assign count_enable  = accept;
  assign pop           = data_out_valid && data_out_ready;
  assign busy          = (state != IDLE);
  assign state_dbg     = state;

`ifdef KEY_XOR_CHAIN_EN
  logic [DATA_W-1:0] prev;

  assign cipher = data_in ^ key_q[key_count] ^ prev;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      prev <= '0;
    end else if (state == IDLE && start) begin
      prev <= '0;
    end else if (accept) begin
      prev <= cipher;
    end
  end
`else
  assign cipher = data_in ^ key_q[key_count];
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      stop_pend <= 1'b0;
    end else begin
      state     <= state_nxt;
      stop_pend <= stop_pend_nxt;
    end
  end

  // Leaving RUN only on key_count==0 with no accept keeps blocks whole.
  always_comb begin
    state_nxt     = state;
    stop_pend_nxt = stop_pend;
    case (state)
      IDLE: begin
        stop_pend_nxt = 1'b0;
        if (start) state_nxt = RUN;
      end
      RUN: begin
        stop_pend_nxt = stop_pend || stop;
        if (stop_pend_nxt && key_count == 2'd0 && !accept) begin
          state_nxt     = DRAIN;
          stop_pend_nxt = 1'b0;
        end
      end
      DRAIN: begin
        if (!data_out_valid || data_out_ready) state_nxt = IDLE;
      end
      default: begin
        state_nxt     = IDLE;
        stop_pend_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < 4; i++) key_q[i] <= KEY_RST[i*DATA_W +: DATA_W];
    end else if (state == IDLE && key_wr_en) begin
      key_q[key_wr_idx] <= key_wr_data;
    end
  end

  // Pop and accept in the same cycle keeps valid high with the new byte.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      data_out       <= '0;
      data_out_valid <= 1'b0;
      block_done     <= 1'b0;
    end else begin
      block_done <= accept && key_rollover;
      if (accept) begin
        data_out       <= cipher;
        data_out_valid <= 1'b1;
      end else if (pop) begin
        data_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/key_xor_stream.md
Name: key_xor_stream

Overview:
- Downstream consumer of the key_counter stage in the USB encryption datapath.
- Holds a 4-byte key and XORs each accepted data byte with the key byte selected by key_count, producing a valid/ready ciphertext stream.
- Drives count_enable back to key_counter once per accepted byte.
- Uses key_rollover to mark 4-byte block boundaries.

Parameters:
- DATA_W, 8, width of data and key bytes.
- KEY_RST, 32'h0000_0000, reset and zeroize value of the key file; byte i = KEY_RST[8i+7:8i].

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  asynchronous active-low reset.
- key_wr_en  input  1  write one key byte; honoured in IDLE only.
- key_wr_idx  input  2  key byte index to write.
- key_wr_data  input  DATA_W  key byte value.
- start  input  1  IDLE->RUN request (pulse).
- stop  input  1  request to end streaming at the next block boundary (pulse).
- data_in  input  DATA_W  plaintext byte.
- data_in_valid  input  1  plaintext byte present.
- data_in_ready  output  1  block can accept a byte this cycle.
- key_count  input  2  current key index from key_counter.
- key_rollover  input  1  high while key_count==3 (last byte of block).
- count_enable  output  1  advance key_counter; combinational, equal to the accept condition.
- data_out  output  DATA_W  ciphertext byte (registered).
- data_out_valid  output  1  ciphertext byte present.
- data_out_ready  input  1  downstream accepts data_out.
- block_done  output  1  one-cycle pulse, registered; the last byte of a 4-byte block was accepted.
- busy  output  1  high in RUN or DRAIN.

Behaviour:
- Clocking and reset: single clock domain; asynchronous active-low reset named n_rst, as fixed.
- Reset values: state=IDLE, key file=KEY_RST, data_out=0, data_out_valid=0, block_done=0, stop_pend=0, busy=0.
- Reset mid-stream discards the output register contents.

- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - key_wr_en writes key[key_wr_idx] = key_wr_data at the clock edge; key_wr_en is ignored in RUN and DRAIN.
  - start -> RUN. start with key_wr_en in the same cycle: write lands, then RUN.
- RUN:
  - accept = data_in_valid & data_in_ready.
  - data_in_ready = !data_out_valid | data_out_ready.
  - On accept: data_out <= data_in ^ key[key_count]; data_out_valid <= 1.
  - count_enable = accept (RUN only). key_count updates one cycle later, so back-to-back accepts use indices 0,1,2,3,0,...
  - On accept with key_rollover=1: block_done pulses the next cycle.
  - Output register: if data_out_valid & data_out_ready & !accept, then data_out_valid <= 0. Simultaneous pop and accept keeps valid=1 with the new byte, giving full throughput (1 byte/cycle).
  - stop sets stop_pend. RUN->DRAIN when stop_pend=1 and key_count==0 and no accept this cycle; clear stop_pend on that transition.
  - If stop arrives while key_count==0 with no accept, go to DRAIN the next cycle. A block is never split.
- DRAIN:
  - data_in_ready=0, count_enable=0.
  - When data_out_valid==0 (or it is popped this cycle), go to IDLE.
- start outside IDLE is ignored. stop in IDLE is ignored.
- Latency: accepted byte -> data_out_valid = 1 clock.
- key_count is not checked against an internal count; key_counter is the single index source.

Optional Feature:
- Macro: KEY_XOR_CHAIN_EN.
- Defined:
  - Chaining register prev (DATA_W, reset 0, cleared on IDLE->RUN).
  - data_out <= data_in ^ key[key_count] ^ prev.
  - prev <= the new data_out on every accept.
- Undefined: no prev register; plain XOR as above.

Test Plan:
- Reset then idle: data_out_valid=0, data_in_ready=0, busy=0, key file=KEY_RST; after reset release, key_count=0.
- Load key 11,22,33,44 (idx 0..3); start; stream 8 bytes 0x00..0x07 with data_out_ready=1 -> outputs 11,23,31,47,15,27,35,43. count_enable high 8 cycles; block_done pulses after bytes 4 and 8.
- Same stream with data_out_ready held low 3 cycles after byte 2 -> data_in_ready=0 during the stall, no byte lost or duplicated, count_enable low while stalled.
- stop pulsed after byte 1 of a block -> bytes 2-4 still accepted, then DRAIN, then IDLE once data_out is popped; busy falls; key_count=0.
- key_wr_en during RUN with idx 0, data 0xFF -> ignored; next byte 0x00 at index 0 outputs 0x11.
- KEY_XOR_CHAIN_EN defined, key 11,22,33,44, data 00,00,00,00 -> outputs 11,33,00,44.
